// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory port arbiter.
package mem_arb_pkg;

  typedef logic req_id_t;

  localparam req_id_t     REQ_CORE              = 1'b0;
  localparam req_id_t     REQ_DBG               = 1'b1;
  localparam int unsigned MAX_OUTSTANDING_LIMIT = 4;

  function automatic req_id_t other_req(input req_id_t id);
    return ~id;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_resp_id_fifo.sv
// In-order FIFO of requester IDs for granted-but-unanswered memory requests.
module resp_id_fifo
  import mem_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  req_id_t          push_id_i,
  input  logic             pop_i,
  output req_id_t          head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0] mem_q, mem_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] inc_ptr(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) return '0;
    return p + 1'b1;
  endfunction

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_id_i;
      wr_ptr_d        = inc_ptr(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = inc_ptr(rd_ptr_q);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-master memory port arbiter (core LSU, UART debug) with hold-until-grant,
// round-robin or fixed priority, and in-order response routing.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 12,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter bit          RR_EN           = 1'b1
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [1:0]                 m_req_i,
  output logic [1:0]                 m_gnt_o,
  output logic [1:0]                 m_rvalid_o,
  input  logic [1:0]                 m_we_i,
  input  logic [1:0][ADDR_WIDTH-1:0] m_addr_i,
  input  logic [1:0][3:0]            m_be_i,
  input  logic [1:0][31:0]           m_wdata_i,
  output logic [1:0][31:0]           m_rdata_o,
  output logic                       s_req_o,
  input  logic                       s_gnt_i,
  input  logic                       s_rvalid_i,
  output logic                       s_we_o,
  output logic [ADDR_WIDTH-1:0]      s_addr_o,
  output logic [3:0]                 s_be_o,
  output logic [31:0]                s_wdata_o,
  input  logic [31:0]                s_rdata_i,
  output logic                       busy_o,
  output logic                       err_o
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic             hold_valid_q, hold_valid_d;
  req_id_t          hold_sel_q, hold_sel_d;
  req_id_t          rr_pri_q, rr_pri_d;
  logic             err_q, err_d;

  req_id_t          pri;
  req_id_t          sel;
  logic             req_sel;
  logic             handshake;
  logic             pop;
  logic             fifo_full, fifo_empty;
  req_id_t          fifo_head;
  logic [CNT_W-1:0] fifo_count;

  // A stalled request keeps its slot until the memory accepts it.
  always_comb begin
    pri = RR_EN ? rr_pri_q : REQ_DBG;
    sel = pri;
    if (hold_valid_q) begin
      sel = hold_sel_q;
    end else if (m_req_i[pri]) begin
      sel = pri;
    end else if (m_req_i[other_req(pri)]) begin
      sel = other_req(pri);
    end
  end

  assign req_sel   = m_req_i[sel];
  assign s_req_o   = rst_ni & req_sel & ~fifo_full;
  assign handshake = s_req_o & s_gnt_i;
  assign pop       = rst_ni & s_rvalid_i & ~fifo_empty;

  always_comb begin
    s_we_o    = 1'b0;
    s_addr_o  = '0;
    s_be_o    = '0;
    s_wdata_o = '0;
    if (req_sel) begin
      s_we_o    = m_we_i[sel];
      s_addr_o  = m_addr_i[sel];
      s_be_o    = m_be_i[sel];
      s_wdata_o = m_wdata_i[sel];
    end
  end

  always_comb begin
    m_gnt_o           = '0;
    m_gnt_o[REQ_CORE] = handshake & (sel == REQ_CORE);
    m_gnt_o[REQ_DBG]  = handshake & (sel == REQ_DBG);
  end

  always_comb begin
    m_rvalid_o = '0;
    m_rdata_o  = '0;
    if (pop) begin
      m_rvalid_o[fifo_head] = 1'b1;
      m_rdata_o[fifo_head]  = s_rdata_i;
    end
  end

  always_comb begin
    hold_valid_d = s_req_o & ~s_gnt_i;
    hold_sel_d   = sel;
    rr_pri_d     = handshake ? other_req(sel) : rr_pri_q;
    err_d        = err_q | (s_rvalid_i & fifo_empty);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hold_valid_q <= 1'b0;
      hold_sel_q   <= REQ_CORE;
      rr_pri_q     <= REQ_DBG;
      err_q        <= 1'b0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_sel_q   <= hold_sel_d;
      rr_pri_q     <= rr_pri_d;
      err_q        <= err_d;
    end
  end

  resp_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .CNT_W (CNT_W)
  ) u_resp_id_fifo (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .push_i    (handshake),
    .push_id_i (sel),
    .pop_i     (pop),
    .head_o    (fifo_head),
    .count_o   (fifo_count),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  assign busy_o = (fifo_count != '0);
  assign err_o  = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter at default parameters.
module tb_mem_port_arbiter;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [1:0]        m_req;
  logic [1:0]        m_gnt;
  logic [1:0]        m_rvalid;
  logic [1:0]        m_we;
  logic [1:0][11:0]  m_addr;
  logic [1:0][3:0]   m_be;
  logic [1:0][31:0]  m_wdata;
  logic [1:0][31:0]  m_rdata;
  logic              s_req;
  logic              s_gnt;
  logic              s_rvalid;
  logic              s_we;
  logic [11:0]       s_addr;
  logic [3:0]        s_be;
  logic [31:0]       s_wdata;
  logic [31:0]       s_rdata;
  logic              busy;
  logic              err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_WIDTH      (12),
    .MAX_OUTSTANDING (2),
    .RR_EN           (1'b1)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .m_req_i    (m_req),
    .m_gnt_o    (m_gnt),
    .m_rvalid_o (m_rvalid),
    .m_we_i     (m_we),
    .m_addr_i   (m_addr),
    .m_be_i     (m_be),
    .m_wdata_i  (m_wdata),
    .m_rdata_o  (m_rdata),
    .s_req_o    (s_req),
    .s_gnt_i    (s_gnt),
    .s_rvalid_i (s_rvalid),
    .s_we_o     (s_we),
    .s_addr_o   (s_addr),
    .s_be_o     (s_be),
    .s_wdata_o  (s_wdata),
    .s_rdata_i  (s_rdata),
    .busy_o     (busy),
    .err_o      (err)
  );

  // Inputs change on the falling edge; outputs are observed 1 time unit later.
  task automatic set_in(input logic [1:0] req, input logic gnt, input logic rv,
                        input logic [31:0] rd);
    @(negedge clk);
    m_req    = req;
    s_gnt    = gnt;
    s_rvalid = rv;
    s_rdata  = rd;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_in(2'b11, 1'b1, 1'b1, 32'h1234_5678);
    checks++;
    if (s_req !== 1'b0) begin failures++; $display("FAIL reset_s_req got=%b exp=0", s_req); end
    checks++;
    if (m_gnt !== 2'b00) begin failures++; $display("FAIL reset_m_gnt got=%b exp=00", m_gnt); end
    checks++;
    if (m_rvalid !== 2'b00) begin failures++; $display("FAIL reset_m_rvalid got=%b exp=00", m_rvalid); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++;
    if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
    @(negedge clk);
    m_req = 2'b00; s_gnt = 1'b0; s_rvalid = 1'b0; s_rdata = '0;
    rst_n = 1'b1;
  endtask

  task automatic test_round_robin();
    logic [1:0]  req_t  [5] = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b00};
    logic        rv_t   [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [31:0] rd_t   [5] = '{32'h0, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
    logic [1:0]  gnt_e  [5] = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b00};
    logic [11:0] addr_e [5] = '{12'h200, 12'h100, 12'h200, 12'h100, 12'h000};
    logic [31:0] wd_e   [5] = '{32'hD1D1_1111, 32'hC0C0_0000, 32'hD1D1_1111, 32'hC0C0_0000, 32'h0};
    logic        we_e   [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [1:0]  rv_e   [5] = '{2'b00, 2'b10, 2'b01, 2'b10, 2'b01};
    logic [31:0] rd1_e  [5] = '{32'h0, 32'h1111_1111, 32'h0, 32'h3333_3333, 32'h0};
    logic [31:0] rd0_e  [5] = '{32'h0, 32'h0, 32'h2222_2222, 32'h0, 32'h4444_4444};
    for (int i = 0; i < 5; i++) begin
      set_in(req_t[i], 1'b1, rv_t[i], rd_t[i]);
      checks++;
      if (m_gnt !== gnt_e[i]) begin failures++; $display("FAIL rr_gnt[%0d] got=%b exp=%b", i, m_gnt, gnt_e[i]); end
      checks++;
      if (s_addr !== addr_e[i]) begin failures++; $display("FAIL rr_addr[%0d] got=%h exp=%h", i, s_addr, addr_e[i]); end
      checks++;
      if (s_wdata !== wd_e[i] || s_we !== we_e[i]) begin
        failures++; $display("FAIL rr_wdata_we[%0d] got=%h/%b exp=%h/%b", i, s_wdata, s_we, wd_e[i], we_e[i]);
      end
      checks++;
      if (m_rvalid !== rv_e[i]) begin failures++; $display("FAIL rr_rvalid[%0d] got=%b exp=%b", i, m_rvalid, rv_e[i]); end
      checks++;
      if (m_rdata[1] !== rd1_e[i] || m_rdata[0] !== rd0_e[i]) begin
        failures++; $display("FAIL rr_rdata[%0d] got=%h/%h exp=%h/%h", i, m_rdata[1], m_rdata[0], rd1_e[i], rd0_e[i]);
      end
    end
    set_in(2'b00, 1'b0, 1'b0, 32'h0);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL rr_busy_drained got=%b exp=0", busy); end
  endtask

  // Requester 1 holds round-robin priority here, so a held sel of 0 is visible.
  task automatic test_hold();
    logic [1:0]  req_t  [7] = '{2'b01, 2'b11, 2'b11, 2'b11, 2'b10, 2'b00, 2'b00};
    logic        gnt_t  [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic        rv_t   [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [1:0]  gnt_e  [7] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00};
    logic [11:0] addr_e [7] = '{12'h100, 12'h100, 12'h100, 12'h100, 12'h200, 12'h000, 12'h000};
    logic [1:0]  rv_e   [7] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b10};
    for (int i = 0; i < 7; i++) begin
      set_in(req_t[i], gnt_t[i], rv_t[i], 32'hAAAA_0000 + i);
      checks++;
      if (m_gnt !== gnt_e[i]) begin failures++; $display("FAIL hold_gnt[%0d] got=%b exp=%b", i, m_gnt, gnt_e[i]); end
      checks++;
      if (s_addr !== addr_e[i]) begin failures++; $display("FAIL hold_addr[%0d] got=%h exp=%h", i, s_addr, addr_e[i]); end
      checks++;
      if (m_rvalid !== rv_e[i]) begin failures++; $display("FAIL hold_rvalid[%0d] got=%b exp=%b", i, m_rvalid, rv_e[i]); end
    end
  endtask

  task automatic test_full();
    logic [1:0]  req_t  [7] = '{2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00};
    logic        rv_t   [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [31:0] rd_t   [7] = '{32'h0, 32'h0, 32'h0, 32'hDEAD_BEEF, 32'h0, 32'h5555_5555, 32'h6666_6666};
    logic        sreq_e [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [1:0]  gnt_e  [7] = '{2'b10, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00};
    logic [1:0]  rv_e   [7] = '{2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b01, 2'b01};
    for (int i = 0; i < 7; i++) begin
      set_in(req_t[i], 1'b1, rv_t[i], rd_t[i]);
      checks++;
      if (s_req !== sreq_e[i]) begin failures++; $display("FAIL full_s_req[%0d] got=%b exp=%b", i, s_req, sreq_e[i]); end
      checks++;
      if (m_gnt !== gnt_e[i]) begin failures++; $display("FAIL full_gnt[%0d] got=%b exp=%b", i, m_gnt, gnt_e[i]); end
      checks++;
      if (m_rvalid !== rv_e[i]) begin failures++; $display("FAIL full_rvalid[%0d] got=%b exp=%b", i, m_rvalid, rv_e[i]); end
      if (i == 2) begin
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL full_busy got=%b exp=1", busy); end
      end
      if (i == 3) begin
        checks++;
        if (m_rdata[1] !== 32'hDEAD_BEEF || m_rdata[0] !== 32'h0) begin
          failures++; $display("FAIL full_rdata got=%h/%h exp=deadbeef/00000000", m_rdata[1], m_rdata[0]);
        end
      end
    end
  endtask

  task automatic test_push_pop();
    set_in(2'b10, 1'b1, 1'b0, 32'h0);
    checks++;
    if (m_gnt !== 2'b10) begin failures++; $display("FAIL pp_gnt_first got=%b exp=10", m_gnt); end
    set_in(2'b01, 1'b1, 1'b1, 32'h7777_7777);
    checks++;
    if (m_gnt !== 2'b01) begin failures++; $display("FAIL pp_gnt_second got=%b exp=01", m_gnt); end
    checks++;
    if (m_rvalid !== 2'b10 || m_rdata[1] !== 32'h7777_7777) begin
      failures++; $display("FAIL pp_resp_first got=%b/%h exp=10/77777777", m_rvalid, m_rdata[1]);
    end
    set_in(2'b00, 1'b0, 1'b1, 32'h8888_8888);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL pp_busy_count1 got=%b exp=1", busy); end
    checks++;
    if (m_rvalid !== 2'b01 || m_rdata[0] !== 32'h8888_8888) begin
      failures++; $display("FAIL pp_resp_second got=%b/%h exp=01/88888888", m_rvalid, m_rdata[0]);
    end
    set_in(2'b00, 1'b0, 1'b0, 32'h0);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL pp_busy_drained got=%b exp=0", busy); end
  endtask

  task automatic test_err_reset();
    checks++;
    if (err !== 1'b0) begin failures++; $display("FAIL err_initial got=%b exp=0", err); end
    set_in(2'b00, 1'b0, 1'b1, 32'h9999_9999);
    checks++;
    if (m_rvalid !== 2'b00) begin failures++; $display("FAIL err_no_rvalid got=%b exp=00", m_rvalid); end
    set_in(2'b00, 1'b0, 1'b0, 32'h0);
    checks++;
    if (err !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL err_set got=%b/%b exp=1/0", err, busy); end
    set_in(2'b00, 1'b0, 1'b0, 32'h0);
    checks++;
    if (err !== 1'b1) begin failures++; $display("FAIL err_sticky got=%b exp=1", err); end

    set_in(2'b10, 1'b1, 1'b0, 32'h0);
    checks++;
    if (m_gnt !== 2'b10) begin failures++; $display("FAIL rst_pre_gnt got=%b exp=10", m_gnt); end
    set_in(2'b01, 1'b0, 1'b0, 32'h0);
    checks++;
    if (s_req !== 1'b1 || m_gnt !== 2'b00) begin failures++; $display("FAIL rst_pre_stall got=%b/%b exp=1/00", s_req, m_gnt); end
    set_in(2'b01, 1'b0, 1'b0, 32'h0);
    checks++;
    if (busy !== 1'b1 || s_addr !== 12'h100) begin failures++; $display("FAIL rst_pre_busy got=%b/%h exp=1/100", busy, s_addr); end

    #2;
    rst_n    = 1'b0;
    s_rvalid = 1'b1;
    #1;
    checks++;
    if (s_req !== 1'b0 || m_gnt !== 2'b00 || m_rvalid !== 2'b00) begin
      failures++; $display("FAIL rst_async_outputs got=%b/%b/%b exp=0/00/00", s_req, m_gnt, m_rvalid);
    end
    checks++;
    if (busy !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL rst_async_state got=%b/%b exp=0/0", busy, err); end

    @(negedge clk);
    rst_n = 1'b1; m_req = 2'b11; s_gnt = 1'b1; s_rvalid = 1'b0; s_rdata = '0;
    #1;
    checks++;
    if (m_gnt !== 2'b10 || s_addr !== 12'h200) begin
      failures++; $display("FAIL rst_post_priority got=%b/%h exp=10/200", m_gnt, s_addr);
    end
    set_in(2'b00, 1'b0, 1'b1, 32'hBBBB_BBBB);
    checks++;
    if (m_rvalid !== 2'b10 || m_rdata[1] !== 32'hBBBB_BBBB) begin
      failures++; $display("FAIL rst_post_resp got=%b/%h exp=10/bbbbbbbb", m_rvalid, m_rdata[1]);
    end
    set_in(2'b00, 1'b0, 1'b1, 32'hCCCC_CCCC);
    checks++;
    if (m_rvalid !== 2'b00) begin failures++; $display("FAIL rst_stale_discarded got=%b exp=00", m_rvalid); end
    set_in(2'b00, 1'b0, 1'b0, 32'h0);
    checks++;
    if (err !== 1'b1) begin failures++; $display("FAIL rst_post_err got=%b exp=1", err); end
  endtask

  initial begin
    rst_n    = 1'b0;
    m_req    = 2'b00;
    s_gnt    = 1'b0;
    s_rvalid = 1'b0;
    s_rdata  = '0;
    m_we     = 2'b10;
    m_addr[0]  = 12'h100;
    m_addr[1]  = 12'h200;
    m_be[0]    = 4'hF;
    m_be[1]    = 4'h3;
    m_wdata[0] = 32'hC0C0_0000;
    m_wdata[1] = 32'hD1D1_1111;

    test_reset();
    test_round_robin();
    test_hold();
    test_full();
    test_push_pop();
    test_err_reset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
